// File: rtl/instr_prefetch_queue.sv
// Decoupled instruction fetcher: sequential req/ack word fetches buffered as {pc, instr} in a FIFO.
// Build option IPQ_BYPASS_EN forwards an ack straight to the head outputs when the queue is empty.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       mem_req_o,
  output logic [31:0]                mem_addr_o,
  input  logic                       mem_ack_i,
  input  logic [31:0]                mem_data_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       deq_i,
  output logic                       valid_o,
  output logic [31:0]                pc_o,
  output logic [31:0]                pc_plus4_o,
  output logic [31:0]                instr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  // state   | meaning
  // IDLE    | no request outstanding (queue has no free slot)
  // WAIT    | request outstanding, returned word is queued
  // DISCARD | request outstanding, returned word is dropped (redirected)
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_pc_next;
  logic [31:0]   r_addr;
  logic          r_req;
  logic          r_valid;
  logic [CW-1:0] r_count, w_count_next;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [31:0]   r_pc_q    [DEPTH];
  logic [31:0]   r_instr_q [DEPTH];
  logic          w_ack, w_byp, w_push, w_pop, w_busy_next, w_issue;
  logic [31:0]   w_redirect_pc;

  assign w_redirect_pc = redirect_pc_i & ~32'd3;
  assign w_ack         = mem_ack_i && (r_state != IDLE);

`ifdef IPQ_BYPASS_EN
  assign w_byp = (r_state == WAIT) && mem_ack_i && !redirect_i && (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  assign w_pop  = deq_i && (r_count != '0) && !redirect_i;
  assign w_push = (r_state == WAIT) && w_ack && !redirect_i && !(w_byp && deq_i);

  always_comb begin
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    if (redirect_i) w_count_next = '0;
  end

  always_comb begin
    w_fetch_pc_next = r_fetch_pc;
    if (redirect_i) w_fetch_pc_next = w_redirect_pc;
    else if ((r_state == WAIT) && w_ack) w_fetch_pc_next = r_fetch_pc + 32'd4;
  end

  // A new request is considered on every edge that leaves nothing outstanding.
  assign w_busy_next = (r_state != IDLE) && !w_ack;
  assign w_issue     = !w_busy_next && (w_count_next < FULL);

  always_comb begin
    w_state_next = r_state;
    if (w_busy_next) begin
      if (redirect_i) w_state_next = DISCARD;
    end else begin
      w_state_next = w_issue ? WAIT : IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
      r_req      <= 1'b0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_req      <= w_busy_next || w_issue;
      if (w_issue) r_addr <= w_fetch_pc_next;
      r_count    <= w_count_next;
      r_valid    <= (w_count_next != '0);
      if (redirect_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= r_addr;
      r_instr_q[r_wr_ptr] <= mem_data_i;
    end
  end

  always_comb begin
    valid_o = r_valid;
    pc_o    = '0;
    instr_o = '0;
    if (r_valid) begin
      pc_o    = r_pc_q[r_rd_ptr];
      instr_o = r_instr_q[r_rd_ptr];
    end
`ifdef IPQ_BYPASS_EN
    else if (w_byp) begin
      valid_o = 1'b1;
      pc_o    = r_addr;
      instr_o = mem_data_i;
    end
`endif
  end

  assign pc_plus4_o = pc_o + 32'd4;
  assign mem_req_o  = r_req;
  assign mem_addr_o = r_addr;
  assign count_o    = r_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench for instr_prefetch_queue: expected fetch addresses and dequeued entries are
// queued by the stimulus thread and popped by a negedge monitor.
module tb_instr_prefetch_queue;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        deq_i = 1'b0;
  logic        valid_o;
  logic [31:0] pc_o, pc_plus4_o, instr_o;
  logic [2:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic [31:0] exp_req[$];
  ent_t        exp_cons[$];
  int          n_checks = 0;
  int          n_errors = 0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .deq_i(deq_i), .valid_o(valid_o), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .instr_o(instr_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_cons(input logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.instr = fdat(pc);
    exp_cons.push_back(e);
  endtask

  // Leaves the bench in cycle 0: reset just released, inputs idle.
  task automatic do_reset(input bit check_vals);
    rst_i = 1'b1; mem_ack_i = 1'b0; deq_i = 1'b0; redirect_i = 1'b0;
    step;
    step;
    if (check_vals) begin
      chk("rst_req", {31'b0, mem_req_o}, 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_valid", {31'b0, valid_o}, 32'd0);
      chk("rst_pc", pc_o, 32'd0);
      chk("rst_pc4", pc_plus4_o, 32'd4);
      chk("rst_instr", instr_o, 32'd0);
      chk("rst_count", {29'b0, count_o}, 32'd0);
    end
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_o && mem_ack_i) begin
        if (exp_req.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL req_unexpected: got addr %h, expected no ack-able request", mem_addr_o);
        end else begin
          chk("req_addr", mem_addr_o, exp_req.pop_front());
        end
      end
      if (valid_o && deq_i && !redirect_i) begin
        if (exp_cons.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL deq_unexpected: got pc %h, expected empty head", pc_o);
        end else begin
          ent_t e;
          e = exp_cons.pop_front();
          chk("deq_pc", pc_o, e.pc);
          chk("deq_instr", instr_o, e.instr);
          chk("deq_pc4", pc_plus4_o, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // streaming: ack and deq every cycle
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) begin
      exp_req.push_back(32'(4 * i));
      push_cons(32'(4 * i));
    end
    step;
    chk("A_first_req", {31'b0, mem_req_o}, 32'd1);
    chk("A_first_addr", mem_addr_o, 32'd0);
    for (int i = 0; i < 8; i++) begin
      mem_ack_i = 1'b1; deq_i = 1'b1; mem_data_i = fdat(mem_addr_o);
      step;
      chk("A_valid", {31'b0, valid_o}, 32'd1);
    end
    mem_ack_i = 1'b0;
    step;
    deq_i = 1'b0;
    chk("A_drained", {29'b0, count_o}, 32'd0);

    // fill to DEPTH, then one deq re-opens exactly one request
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) exp_req.push_back(32'(4 * i));
    step;
    for (int i = 0; i < 4; i++) begin
      mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
      step;
    end
    chk("B_full_count", {29'b0, count_o}, 32'd4);
    chk("B_full_req", {31'b0, mem_req_o}, 32'd0);
    mem_data_i = fdat(mem_addr_o);
    step;
    chk("B_ign_ack_count", {29'b0, count_o}, 32'd4);
    chk("B_ign_ack_req", {31'b0, mem_req_o}, 32'd0);
    mem_ack_i = 1'b0; deq_i = 1'b1;
    push_cons(32'd0);
    step;
    deq_i = 1'b0;
    chk("B_deq_count", {29'b0, count_o}, 32'd3);
    chk("B_reopen_req", {31'b0, mem_req_o}, 32'd1);
    chk("B_reopen_addr", mem_addr_o, 32'd16);
    mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
    step;
    mem_ack_i = 1'b0;
    chk("B_refull_count", {29'b0, count_o}, 32'd4);
    chk("B_refull_req", {31'b0, mem_req_o}, 32'd0);
    for (int i = 1; i < 5; i++) push_cons(32'(4 * i));
    deq_i = 1'b1;
    repeat (4) step;
    deq_i = 1'b0;
    chk("B_empty_count", {29'b0, count_o}, 32'd0);

    // redirect while a slow ack is pending
    do_reset(1'b0);
    step;
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    step;
    redirect_i = 1'b0;
    chk("C_hold_req", {31'b0, mem_req_o}, 32'd1);
    chk("C_hold_addr", mem_addr_o, 32'd0);
    chk("C_hold_count", {29'b0, count_o}, 32'd0);
    step;
    chk("C_hold_addr2", mem_addr_o, 32'd0);
    exp_req.push_back(32'd0);
    exp_req.push_back(32'h40);
    mem_ack_i = 1'b1; mem_data_i = fdat(32'd0);
    step;
    chk("C_new_addr", mem_addr_o, 32'h40);
    chk("C_drop_valid", {31'b0, valid_o}, 32'd0);
    mem_data_i = fdat(mem_addr_o);
    step;
    mem_ack_i = 1'b0;
    chk("C_first_pc", pc_o, 32'h40);
    chk("C_first_instr", instr_o, fdat(32'h40));
    push_cons(32'h40);
    deq_i = 1'b1;
    step;
    deq_i = 1'b0;

    // redirect + ack + deq together with two entries queued
    do_reset(1'b0);
    exp_req.push_back(32'd0);
    exp_req.push_back(32'd4);
    exp_req.push_back(32'd8);
    exp_req.push_back(32'h104);
    step;
    for (int i = 0; i < 2; i++) begin
      mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
      step;
    end
    chk("D_pre_count", {29'b0, count_o}, 32'd2);
    mem_data_i = fdat(mem_addr_o); deq_i = 1'b1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0107;
    step;
    mem_ack_i = 1'b0; deq_i = 1'b0; redirect_i = 1'b0;
    chk("D_count", {29'b0, count_o}, 32'd0);
    chk("D_valid", {31'b0, valid_o}, 32'd0);
    chk("D_instr", instr_o, 32'd0);
    chk("D_req", {31'b0, mem_req_o}, 32'd1);
    chk("D_addr", mem_addr_o, 32'h104);
    mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
    step;
    mem_ack_i = 1'b0;
    chk("D_pc", pc_o, 32'h104);
    chk("D_count1", {29'b0, count_o}, 32'd1);
    push_cons(32'h104);
    deq_i = 1'b1;
    step;
    deq_i = 1'b0;

    // PC wrap at the top of the address space
    do_reset(1'b0);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    step;
    redirect_i = 1'b0;
    chk("E_addr", mem_addr_o, 32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC);
    exp_req.push_back(32'h0);
    mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
    step;
    chk("E_wrap_addr", mem_addr_o, 32'h0);
    chk("E_head_pc", pc_o, 32'hFFFF_FFFC);
    chk("E_head_pc4", pc_plus4_o, 32'h0);
    mem_data_i = fdat(mem_addr_o);
    step;
    mem_ack_i = 1'b0;
    chk("E_count", {29'b0, count_o}, 32'd2);
    push_cons(32'hFFFF_FFFC);
    push_cons(32'h0);
    deq_i = 1'b1;
    step;
    step;
    deq_i = 1'b0;

    // reset with a request outstanding and an ack arriving during reset
    chk("F_pre_req", {31'b0, mem_req_o}, 32'd1);
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
    step;
    chk("F_req", {31'b0, mem_req_o}, 32'd0);
    chk("F_count", {29'b0, count_o}, 32'd0);
    chk("F_addr", mem_addr_o, 32'd0);
    rst_i = 1'b0; mem_ack_i = 1'b0;
    step;
    chk("F_restart_req", {31'b0, mem_req_o}, 32'd1);
    chk("F_restart_count", {29'b0, count_o}, 32'd0);
    exp_req.push_back(32'd0);
    push_cons(32'd0);
    mem_ack_i = 1'b1; mem_data_i = fdat(mem_addr_o);
    step;
    mem_ack_i = 1'b0; deq_i = 1'b1;
    step;
    deq_i = 1'b0;
    step;

    chk("sb_req_left", 32'(exp_req.size()), 32'd0);
    chk("sb_cons_left", 32'(exp_cons.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
